// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial sequencer: state encoding,
// default widths and the saturated result value.
package factorial_pkg;

  localparam int DEF_N_W     = 32;
  localparam int DEF_R_W     = 64;
  localparam int DEF_MUL_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DEF_R_W-1:0] RESULT_SAT = '1;

endpackage

// File: rtl/factorial_seq_ctrl_if.sv
// Request/response bundle between the function-evaluation front end (master)
// and the factorial sequencer (slave).
interface factorial_seq_ctrl_if #(
  parameter int N_W = 32,
  parameter int R_W = 64
);

  logic           req_valid;
  logic           req_ready;
  logic [N_W-1:0] req_n;
  logic           abort;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [R_W-1:0] rsp_result;
  logic           rsp_ovf;
  logic           busy;

  modport master (
    output req_valid, req_n, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_n, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_ovf, busy
  );

endinterface

// File: rtl/factorial_mul_pipe.sv
// Unsigned A_W x B_W multiplier with LAT register stages and a matching
// valid shift chain; flush clears the valid chain on the next edge.
module factorial_mul_pipe
  import factorial_pkg::*;
#(
  parameter int A_W = DEF_R_W,
  parameter int B_W = DEF_N_W,
  parameter int LAT = DEF_MUL_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             out_valid,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic           vld_reg  [LAT];
  logic [P_W-1:0] prod_reg [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_reg[gi] <= 1'b0;
          end else begin
            vld_reg[gi] <= in_valid && !flush;
          end
        end

        always_ff @(posedge clk) begin
          prod_reg[gi] <= P_W'(a) * P_W'(b);
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vld_reg[gi] <= 1'b0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1] && !flush;
          end
        end

        always_ff @(posedge clk) begin
          prod_reg[gi] <= prod_reg[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = vld_reg[LAT-1];
  assign p         = prod_reg[LAT-1];

endmodule

// File: rtl/factorial_seq_ctrl.sv
// Iterative n! sequencer: one multiply in flight at a time, acc <= acc*k for
// k = 2..n, with saturation and early exit once the product exceeds R_W bits.
module factorial_seq_ctrl
  import factorial_pkg::*;
#(
  parameter int N_W     = DEF_N_W,
  parameter int R_W     = DEF_R_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic clk,
  input  logic rst_n,
  factorial_seq_ctrl_if.slave bus
);

  localparam int P_W = R_W + N_W;

  state_t         state_reg;
  logic [R_W-1:0] acc_reg;
  logic [N_W-1:0] k_reg;
  logic [N_W-1:0] n_reg;
  logic           req_ready_reg;
  logic           rsp_valid_reg;
  logic [R_W-1:0] rsp_result_reg;
  logic           rsp_ovf_reg;
  logic           busy_reg;

  logic           mul_issue;
  logic           mul_flush;
  logic           mul_valid;
  logic [P_W-1:0] mul_p;

  assign mul_issue = (state_reg == ISSUE);
  // Abort must also kill a product issued in the same cycle.
  assign mul_flush = bus.abort && (state_reg != IDLE);

  factorial_mul_pipe #(
    .A_W (R_W),
    .B_W (N_W),
    .LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (mul_flush),
    .in_valid  (mul_issue),
    .a         (acc_reg),
    .b         (k_reg),
    .out_valid (mul_valid),
    .p         (mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      acc_reg        <= R_W'(1);
      k_reg          <= '0;
      n_reg          <= '0;
      req_ready_reg  <= 1'b1;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_ovf_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else if (mul_flush) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            n_reg         <= bus.req_n;
            acc_reg       <= R_W'(1);
            k_reg         <= N_W'(2);
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (bus.req_n <= N_W'(1)) begin
              state_reg      <= DONE;
              rsp_valid_reg  <= 1'b1;
              rsp_result_reg <= R_W'(1);
              rsp_ovf_reg    <= 1'b0;
            end else begin
              state_reg <= ISSUE;
            end
          end
        end

        ISSUE: begin
          state_reg <= WAIT;
        end

        WAIT: begin
          if (mul_valid) begin
            if (|mul_p[P_W-1:R_W]) begin
              state_reg      <= DONE;
              rsp_valid_reg  <= 1'b1;
              rsp_result_reg <= '1;
              rsp_ovf_reg    <= 1'b1;
            end else begin
              acc_reg <= mul_p[R_W-1:0];
              if (k_reg == n_reg) begin
                state_reg      <= DONE;
                rsp_valid_reg  <= 1'b1;
                rsp_result_reg <= mul_p[R_W-1:0];
                rsp_ovf_reg    <= 1'b0;
              end else begin
                k_reg     <= k_reg + N_W'(1);
                state_reg <= ISSUE;
              end
            end
          end
        end

        DONE: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_ovf    = rsp_ovf_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Self-checking bench for factorial_seq_ctrl: directed cases plus random n,
// compared against a wide-arithmetic factorial model.
module tb_factorial_seq_ctrl;
  import factorial_pkg::*;

  localparam int N_W     = 32;
  localparam int R_W     = 64;
  localparam int MUL_LAT = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_res;

  factorial_seq_ctrl_if #(.N_W(N_W), .R_W(R_W)) bus ();

  factorial_seq_ctrl #(
    .N_W     (N_W),
    .R_W     (R_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // n! with 128-bit arithmetic; stops at the first product that needs more than 64 bits.
  task automatic model(input logic [31:0] n, output logic [63:0] r, output logic o, output int m);
    logic [127:0] a;
    a = 128'd1;
    o = 1'b0;
    m = 0;
    for (longint kk = 2; kk <= longint'(n); kk++) begin
      a = a * 128'(kk);
      m++;
      if (a[127:64] != 64'd0) begin
        o = 1'b1;
        break;
      end
    end
    r = o ? RESULT_SAT : a[63:0];
  endtask

  task automatic do_req(input logic [31:0] n, input int hold);
    logic [63:0] er;
    logic        eo;
    int          em;
    int          cyc;
    int          iss;
    model(n, er, eo, em);
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_n     = n;
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 1;
    iss = 0;
    while (!bus.rsp_valid && cyc < 5000) begin
      if (dut.mul_issue) iss++;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(1 + em * (MUL_LAT + 1)));
    chk("result", bus.rsp_result, er);
    chk("ovf", 64'(bus.rsp_ovf), 64'(eo));
    chk("issues", 64'(iss), 64'(em));
    last_res = bus.rsp_result;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1;
      bus.req_n     = n + 32'd1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_result", bus.rsp_result, er);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", 64'(bus.rsp_valid), 64'd0);
    chk("post_hs_ready", 64'(bus.req_ready), 64'd1);
    $display("txn n=%0d hold=%0d result=0x%016h ovf=%0b latency=%0d issues=%0d",
             n, hold, last_res, eo, cyc, iss);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 64'd0);
    chk({tag, "_rsp_ovf"}, 64'(bus.rsp_ovf), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic start_and_wait(input logic [31:0] n, input int cycles);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_n     = n;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic expect_silence(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_n     = '0;
    bus.abort     = 1'b0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_req(32'd0, 0);
    do_req(32'd1, 0);
    do_req(32'd5, 0);
    chk("n5_const", last_res, 64'd120);
    do_req(32'd20, 0);
    chk("n20_const", last_res, 64'h21C3677C82B40000);
    do_req(32'd25, 0);
    chk("n25_sat", last_res, 64'hFFFFFFFFFFFFFFFF);

    // Stalled consumer: result held, stray request ignored, then next request served.
    do_req(32'd3, 5);
    chk("n3_const", last_res, 64'd6);
    do_req(32'd4, 0);
    chk("n4_const", last_res, 64'd24);

    // Abort while idle does nothing.
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("idle_abort_ready", 64'(bus.req_ready), 64'd1);
    chk("idle_abort_busy", 64'(bus.busy), 64'd0);

    // Abort in cycle 6 of n=10.
    start_and_wait(32'd10, 6);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    expect_silence("abort_no_rsp");
    do_req(32'd3, 0);

    // Reset pulse in the middle of a WAIT.
    start_and_wait(32'd10, 8);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    expect_silence("reset_no_rsp");
    do_req(32'd3, 0);

    for (int t = 0; t < 10; t++) begin
      do_req(32'($urandom_range(0, 24)), int'($urandom_range(0, 3)));
    end
    do_req(32'hFFFF_FFFF, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/factorial_seq_ctrl.md
Name: factorial_seq_ctrl

Overview:
Sequencer that computes n! iteratively by time-sharing one pipelined multiplier across successive partial products.
Sits behind the function-evaluation front end: it accepts one request at a time on a valid/ready interface and returns a 64-bit result plus an overflow flag on a second valid/ready interface.
It owns the loop counter, accumulator and multiplier issue/retire timing.

Parameters:
N_W, 32, width of operand n and of the loop counter k
R_W, 64, width of result accumulator
MUL_LAT, 2, multiplier pipeline latency in cycles (>=1)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_n  input  N_W  operand n, sampled on the req handshake
abort  input  1  synchronous cancel of the current operation
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_result  output  R_W  n! or saturated all-ones value
rsp_ovf  output  1  result exceeded R_W bits
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_ovf=0; busy=0; acc=1; k=0; all multiplier valid bits cleared.
- Reset mid-operation: any in-flight product is discarded and no response is produced.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch n, set acc=1, k=2.
    - If n<=1, go to DONE with result 1.
    - Otherwise go to ISSUE.
  - ISSUE: present acc (R_W) x k (N_W) to the multiplier for exactly one cycle, then go to WAIT.
  - WAIT: hold until the product valid strobe, which arrives MUL_LAT cycles after issue. The product is R_W+N_W bits.
    - If product[R_W+N_W-1:R_W] != 0: go to DONE with result = all ones, ovf=1 (early termination).
    - Else acc <= product[R_W-1:0]. If k==n go to DONE with result=acc, ovf=0. Else k <= k+1 and go to ISSUE.
  - DONE: rsp_valid=1. rsp_result and rsp_ovf stay stable until rsp_valid&&rsp_ready, then go to IDLE.
- req_ready=0 in all states except IDLE; req_valid outside IDLE is ignored and must not be latched.
- Latency from the acceptance edge to rsp_valid high: 1 + max(n-1,0)*(MUL_LAT+1) cycles. For overflow, replace n-1 with the number of multiplies performed.
- With R_W=64, overflow is detected at k=21 because 21! > 2^64-1.
- abort: in any non-IDLE state, go to IDLE on the next edge, flush the multiplier pipe and drop rsp_valid. abort in IDLE has no effect.
  - abort together with a DONE handshake: both lead to IDLE; the response counts as delivered.
- Back-to-back: a new request can be accepted the cycle after the DONE handshake, because IDLE is entered on that edge.
- k never wraps: the loop ends at k==n or on overflow first.
- Outputs are registered; no combinational path from req_* to rsp_*.

Decomposition:
- Shared package factorial_pkg holds:
  - the state encoding constants (IDLE, ISSUE, WAIT, DONE);
  - default widths N_W/R_W and MUL_LAT;
  - the saturation constant RESULT_SAT (all ones, R_W bits).
- One sub-module: factorial_mul_pipe, an R_W x N_W unsigned multiplier.
  - MUL_LAT register stages, each with an in_valid/out_valid shift chain.
  - Asynchronous active-low reset on the valid bits; a flush input clears them synchronously.
- The controller holds the FSM, acc, k, n and the response registers.

Test Plan:
- n=0, then n=1 -> rsp_result=1, rsp_ovf=0, rsp_valid 1 cycle after acceptance, 0 multiplier issues.
- n=5, MUL_LAT=2, rsp_ready=1 -> rsp_result=120, ovf=0, rsp_valid exactly 13 cycles after acceptance, 4 issues.
- n=20 -> rsp_result=0x21C3677C82B40000, ovf=0, 58 cycles.
- n=25 -> rsp_result=0xFFFFFFFFFFFFFFFF, ovf=1, early exit after 20 multiplies, 61 cycles.
- n=3 with rsp_ready held low 5 cycles -> result 6 stays stable; req_ready=0 and a req_valid with n=4 is ignored; after the handshake, the next request n=4 returns 24.
- n=10 with abort in cycle 6 -> IDLE next cycle, no rsp_valid; then n=3 returns 6.
- n=10 with rst_n pulsed low mid-WAIT -> all outputs at reset values immediately; then n=3 returns 6.
